// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: FSM states, green-direction
// memory, lamp bundle and the state-to-lamp decode.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED,
    ST_NS_GREEN,
    ST_NS_YELLOW,
    ST_EW_GREEN,
    ST_EW_YELLOW,
    ST_PED_WALK,
    ST_EMG
  } state_t;

  typedef enum logic {
    DIR_NS,
    DIR_EW
  } dir_t;

  typedef struct packed {
    logic ns_green;
    logic ns_yellow;
    logic ew_green;
    logic ew_yellow;
    logic ped_walk;
  } lamps_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Emergency preemption always clears the north-south approach.
  function automatic lamps_t lamps_for(input state_t s);
    lamps_t l;
    l = '0;
    case (s)
      ST_NS_GREEN:  l.ns_green  = 1'b1;
      ST_NS_YELLOW: l.ns_yellow = 1'b1;
      ST_EW_GREEN:  l.ew_green  = 1'b1;
      ST_EW_YELLOW: l.ew_yellow = 1'b1;
      ST_PED_WALK:  l.ped_walk  = 1'b1;
      ST_EMG:       l.ns_green  = 1'b1;
      default:      l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clock timing tick every PRESCALE_MAX
// clocks; never restarted by the FSM so phase stays constant.
module tick_prescaler #(
  parameter int PRESCALE_MAX = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE_MAX) + 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE_MAX - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/traffic_controller.sv
// Two-way intersection controller with pedestrian phase and emergency
// preemption; state, latches and lamp drives are all registered.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int PRESCALE_MAX       = 100000000,
  parameter int T_NS_GREEN_TICKS   = 30,
  parameter int T_NS_YELLOW_TICKS  = 3,
  parameter int T_EW_GREEN_TICKS   = 25,
  parameter int T_EW_YELLOW_TICKS  = 3,
  parameter int T_PED_WALK_TICKS   = 10,
  parameter int T_ALL_RED_TICKS    = 2,
  parameter int T_EMG_GREEN_TICKS  = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ped_req_btn,
  input  logic emergency,
  input  logic emergency_clear,
  output logic ns_green,
  output logic ns_yellow,
  output logic ew_green,
  output logic ew_yellow,
  output logic ped_walk
);

  localparam int T_MAX = max_int(max_int(max_int(T_NS_GREEN_TICKS, T_NS_YELLOW_TICKS),
                                         max_int(T_EW_GREEN_TICKS, T_EW_YELLOW_TICKS)),
                                 max_int(max_int(T_PED_WALK_TICKS, T_ALL_RED_TICKS),
                                         T_EMG_GREEN_TICKS));
  localparam int DW = $clog2(T_MAX) + 1;

  logic          tick;
  state_t        state, next_state;
  dir_t          next_dir, next_dir_d;
  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_limit;
  logic          dwell_done;
  logic          entering;
  logic          ped_pending;
  logic          clear_seen;
  lamps_t        lamps;

  tick_prescaler #(
    .PRESCALE_MAX(PRESCALE_MAX)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    dwell_limit = '0;
    case (state)
      ST_ALL_RED:   dwell_limit = DW'(T_ALL_RED_TICKS - 1);
      ST_NS_GREEN:  dwell_limit = DW'(T_NS_GREEN_TICKS - 1);
      ST_NS_YELLOW: dwell_limit = DW'(T_NS_YELLOW_TICKS - 1);
      ST_EW_GREEN:  dwell_limit = DW'(T_EW_GREEN_TICKS - 1);
      ST_EW_YELLOW: dwell_limit = DW'(T_EW_YELLOW_TICKS - 1);
      ST_PED_WALK:  dwell_limit = DW'(T_PED_WALK_TICKS - 1);
      ST_EMG:       dwell_limit = DW'(T_EMG_GREEN_TICKS - 1);
      default:      dwell_limit = '0;
    endcase
  end

  assign dwell_done = tick && (dwell == dwell_limit);

  // Emergency preempts every transition; EMG leaves only once the minimum
  // green has elapsed, a clear was seen and the request has dropped.
  always_comb begin
    next_state = state;
    next_dir_d = next_dir;
    if (emergency && (state != ST_EMG)) begin
      next_state = ST_EMG;
    end else begin
      case (state)
        ST_ALL_RED: if (dwell_done) begin
          if (ped_pending)             next_state = ST_PED_WALK;
          else if (next_dir == DIR_NS) next_state = ST_NS_GREEN;
          else                         next_state = ST_EW_GREEN;
        end
        ST_NS_GREEN:  if (dwell_done) next_state = ST_NS_YELLOW;
        ST_NS_YELLOW: if (dwell_done) begin
          next_state = ST_ALL_RED;
          next_dir_d = DIR_EW;
        end
        ST_EW_GREEN:  if (dwell_done) next_state = ST_EW_YELLOW;
        ST_EW_YELLOW: if (dwell_done) begin
          next_state = ST_ALL_RED;
          next_dir_d = DIR_NS;
        end
        ST_PED_WALK:  if (dwell_done) next_state = ST_ALL_RED;
        ST_EMG: if (tick && (dwell >= dwell_limit) && clear_seen && !emergency) begin
          next_state = ST_ALL_RED;
          next_dir_d = DIR_EW;
        end
        default: next_state = ST_ALL_RED;
      endcase
    end
  end

  assign entering = (next_state != state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ALL_RED;
      next_dir <= DIR_NS;
      lamps    <= '0;
    end else begin
      state    <= next_state;
      next_dir <= next_dir_d;
      lamps    <= lamps_for(next_state);
    end
  end

  // Dwell saturates so an indefinitely held EMG cannot wrap below its minimum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if (entering) begin
      dwell <= '0;
    end else if (tick && (dwell != '1)) begin
      dwell <= dwell + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      clear_seen  <= 1'b0;
    end else begin
      if (ped_req_btn) begin
        ped_pending <= 1'b1;
      end else if (entering && (next_state == ST_PED_WALK)) begin
        ped_pending <= 1'b0;
      end
      if (entering && (next_state == ST_EMG)) begin
        clear_seen <= 1'b0;
      end else if ((state == ST_EMG) && emergency_clear) begin
        clear_seen <= 1'b1;
      end
    end
  end

  assign ns_green  = lamps.ns_green;
  assign ns_yellow = lamps.ns_yellow;
  assign ew_green  = lamps.ew_green;
  assign ew_yellow = lamps.ew_yellow;
  assign ped_walk  = lamps.ped_walk;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller: expected lamp vectors are queued per
// clock and popped against the DUT on every falling edge.
module tb_traffic_controller;

  localparam logic [4:0] L_RED = 5'b00000;
  localparam logic [4:0] L_NSG = 5'b10000;
  localparam logic [4:0] L_NSY = 5'b01000;
  localparam logic [4:0] L_EWG = 5'b00100;
  localparam logic [4:0] L_EWY = 5'b00010;
  localparam logic [4:0] L_PED = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ped_req_btn = 1'b0;
  logic emergency = 1'b0;
  logic emergency_clear = 1'b0;
  logic ns_green, ns_yellow, ew_green, ew_yellow, ped_walk;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  traffic_controller #(
    .PRESCALE_MAX     (2),
    .T_NS_GREEN_TICKS (6),
    .T_NS_YELLOW_TICKS(2),
    .T_EW_GREEN_TICKS (5),
    .T_EW_YELLOW_TICKS(2),
    .T_PED_WALK_TICKS (4),
    .T_ALL_RED_TICKS  (1),
    .T_EMG_GREEN_TICKS(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ped_req_btn    (ped_req_btn),
    .emergency      (emergency),
    .emergency_clear(emergency_clear),
    .ns_green       (ns_green),
    .ns_yellow      (ns_yellow),
    .ew_green       (ew_green),
    .ew_yellow      (ew_yellow),
    .ped_walk       (ped_walk)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [4:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Every sampled clock also checks that at most one lamp drive is high.
  task automatic check_output(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {ns_green, ns_yellow, ew_green, ew_yellow, ped_walk};
    checks++;
    assert ($onehot0(obs)) else begin
      failures++;
      $error("FAIL %s_onehot observed=%b required=onehot0", tag, obs);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s_queue observed=%b required=queued_entry", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%b required=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check_output(tag);
    end
  endtask

  task automatic apply_stimulus(input logic ped, input logic emg, input logic clr);
    ped_req_btn     = ped;
    emergency       = emg;
    emergency_clear = clr;
  endtask

  // Asserts reset off-edge, checks outputs drop at once and stay low, then
  // releases on a falling edge so the next rising edge is the first active one.
  task automatic do_reset(input string tag);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    push_exp(L_RED, 1);
    check_output({tag, "_async"});
    push_exp(L_RED, 2);
    step({tag, "_held"}, 2);
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string tag);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s_drain observed=%0d required=0", tag, exp_q.size());
    end
  endtask

  initial begin
    $display("[TB] start");
    #1;

    // Free-running cycle after reset
    do_reset("rst0");
    push_exp(L_RED, 1); push_exp(L_NSG, 12); push_exp(L_NSY, 4); push_exp(L_RED, 2);
    push_exp(L_EWG, 10); push_exp(L_EWY, 4); push_exp(L_RED, 2); push_exp(L_NSG, 3);
    step("cycle", 38);
    check_drained("cycle");

    // Pedestrian pulse during NS green
    do_reset("rst1");
    push_exp(L_RED, 1); push_exp(L_NSG, 3);
    step("ped_pre", 4);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    push_exp(L_NSG, 1);
    step("ped_press", 1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    push_exp(L_NSG, 8); push_exp(L_NSY, 4); push_exp(L_RED, 2); push_exp(L_PED, 8);
    push_exp(L_RED, 2); push_exp(L_EWG, 10); push_exp(L_EWY, 1);
    step("ped_seq", 35);
    check_drained("ped");

    // Emergency held 20 clocks during EW green, clear pulse while held
    do_reset("rst2");
    push_exp(L_RED, 1); push_exp(L_NSG, 12); push_exp(L_NSY, 4); push_exp(L_RED, 2);
    push_exp(L_EWG, 3);
    step("emg_pre", 22);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    push_exp(L_NSG, 21); push_exp(L_RED, 2); push_exp(L_EWG, 10);
    step("emg_hold", 10);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    step("emg_clr", 1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    step("emg_hold2", 9);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    step("emg_exit", 13);
    check_drained("emg");

    // Clear outside EMG ignored; emergency dropped without clear holds EMG
    do_reset("rst3");
    push_exp(L_RED, 1); push_exp(L_NSG, 3);
    step("stuck_pre", 4);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    push_exp(L_NSG, 1);
    step("stuck_clr_out", 1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    push_exp(L_NSG, 1);
    step("stuck_enter", 1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    push_exp(L_NSG, 40);
    step("stuck_hold", 40);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    push_exp(L_NSG, 1);
    step("stuck_clr", 1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    push_exp(L_RED, 2); push_exp(L_EWG, 3);
    step("stuck_exit", 5);
    check_drained("stuck");

    // Short emergency: EMG must still last the full 8-tick minimum
    do_reset("rst4");
    push_exp(L_RED, 1); push_exp(L_NSG, 2);
    step("min_pre", 3);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    push_exp(L_NSG, 1);
    step("min_enter", 1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    push_exp(L_NSG, 1);
    step("min_clr", 1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    push_exp(L_NSG, 14); push_exp(L_RED, 2); push_exp(L_EWG, 10);
    step("min_seq", 26);
    check_drained("min");

    // Reset during PED_WALK with a fresh request pending
    do_reset("rst5");
    push_exp(L_RED, 1); push_exp(L_NSG, 3);
    step("pr_pre", 4);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    push_exp(L_NSG, 1);
    step("pr_press", 1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    push_exp(L_NSG, 8); push_exp(L_NSY, 4); push_exp(L_RED, 2); push_exp(L_PED, 3);
    step("pr_walk", 17);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    push_exp(L_PED, 1);
    step("pr_repress", 1);
    do_reset("rst_ped");
    push_exp(L_RED, 1); push_exp(L_NSG, 12); push_exp(L_NSY, 4); push_exp(L_RED, 2);
    push_exp(L_EWG, 10); push_exp(L_EWY, 4); push_exp(L_RED, 2); push_exp(L_NSG, 2);
    step("pr_after", 37);
    check_drained("pr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_controller.md
TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 Parameter PRESCALE_MAX, default 100000000; clocks per timing tick, value 1 or greater.
REQ-002 Parameters T_NS_GREEN_TICKS=30, T_NS_YELLOW_TICKS=3, T_EW_GREEN_TICKS=25, T_EW_YELLOW_TICKS=3, T_PED_WALK_TICKS=10, T_ALL_RED_TICKS=2, T_EMG_GREEN_TICKS=15; state dwell in ticks, each value 1 or greater.
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ped_req_btn  input  1  pedestrian request; a one-clock pulse is sufficient.
REQ-006 emergency  input  1  emergency preemption request, level.
REQ-007 emergency_clear  input  1  emergency release request; a one-clock pulse is sufficient.
REQ-008 ns_green, ns_yellow, ew_green, ew_yellow, ped_walk  output  1 each  lamp drives; a direction is red when neither its green nor its yellow output is high.

Function
REQ-009 The prescaler SHALL be a free-running counter over 0..PRESCALE_MAX-1 that pulses tick for one clock at PRESCALE_MAX-1; it is not restarted on state changes.
REQ-010 The dwell counter SHALL reset to 0 on every state entry and advance on each tick; a state SHALL exit on the tick at which the counter equals T-1, i.e. after exactly T ticks.
REQ-011 The states SHALL be ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK and EMG; all state and outputs are registered.
REQ-012 Outputs SHALL be: NS_GREEN gives ns_green; NS_YELLOW gives ns_yellow; EW_GREEN gives ew_green; EW_YELLOW gives ew_yellow; PED_WALK gives ped_walk only; EMG gives ns_green only; ALL_RED gives all outputs 0.
REQ-013 Normal transitions SHALL be NS_GREEN->NS_YELLOW->ALL_RED (next_dir:=EW) and EW_GREEN->EW_YELLOW->ALL_RED (next_dir:=NS).
REQ-014 On ALL_RED expiry, the controller SHALL enter PED_WALK if ped_pending is set, otherwise NS_GREEN when next_dir=NS and EW_GREEN when next_dir=EW.
REQ-015 On PED_WALK expiry, the controller SHALL enter ALL_RED with next_dir unchanged.
REQ-016 ped_pending SHALL set on any clock with ped_req_btn=1, clear on entry to PED_WALK (set wins if both occur in the same clock), and persist through EMG.
REQ-017 emergency=1 SHALL force entry to EMG on the next clock edge from any non-EMG state, overriding any transition in that clock.
REQ-018 A clear_seen flag SHALL reset on EMG entry and set on any clock in EMG with emergency_clear=1.
REQ-019 EMG SHALL exit to ALL_RED with next_dir:=EW on the first tick at which the dwell counter is at least T_EMG_GREEN_TICKS-1, clear_seen=1 and emergency=0; otherwise EMG holds indefinitely.
REQ-020 emergency_clear outside EMG SHALL be ignored.
REQ-021 At most one of ns_green, ns_yellow, ew_green, ew_yellow, ped_walk SHALL be high in any clock, and ped_walk SHALL never coincide with any vehicle green or yellow.
REQ-022 Counter widths SHALL be $clog2 of the largest relevant parameter plus 1, with no wrap inside a state.

Reset
REQ-023 While rst_n=0, the controller SHALL force state ALL_RED, next_dir=NS, prescaler=0, dwell=0, ped_pending=0 and clear_seen=0, with all outputs 0, asynchronously.
REQ-024 After release, the first state SHALL be ALL_RED for T_ALL_RED_TICKS, followed by NS_GREEN.
REQ-025 Reset asserted mid-operation, including in EMG or PED_WALK, SHALL immediately produce all outputs 0.

Structure
REQ-026 The state enum and the direction type SHALL be placed in package traffic_pkg.
REQ-027 The prescaler SHALL be a sub-module tick_prescaler (parameter PRESCALE_MAX, ports clk, rst_n, tick); the FSM, latches and dwell counter stay in traffic_controller.

Verification
All scenarios use PRESCALE_MAX=2, NS_GREEN=6, NS_YELLOW=2, EW_GREEN=5, EW_YELLOW=2, PED_WALK=4, ALL_RED=1, EMG=8.
REQ-028 Reset release, no inputs: expect ALL_RED, then ns_green for 12 clocks, ns_yellow 4, all-red 2, ew_green 10, ew_yellow 4, all-red 2, then ns_green again.
REQ-029 One-clock ped_req_btn pulse during NS_GREEN: expect NS_YELLOW, ALL_RED, ped_walk high for 8 clocks with every lamp output 0, then ALL_RED, then ew_green.
REQ-030 emergency=1 during EW_GREEN: on the next clock expect ns_green=1 and ew_green=0; with emergency held 20 clocks, a one-clock emergency_clear while emergency=1, then emergency=0, expect EMG held until the 8-tick minimum, then ALL_RED, then ew_green.
REQ-031 emergency dropped without emergency_clear: expect EMG (ns_green=1) held indefinitely.
REQ-032 rst_n asserted during PED_WALK: expect all outputs 0 immediately and ped_pending cleared; after release expect the REQ-028 sequence.
REQ-033 Every clock of every scenario: assert the REQ-021 one-hot and ped_walk exclusivity rules.
